// File: rtl/spi_pkg.sv
// Shared types and command-byte field definitions for the SPI command decoder.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrite,
        StRead,
        StDiscard
    } state_e;

    localparam int unsigned NUM_REGS      = 16;
    localparam int unsigned CMD_WR_BIT    = 7;
    localparam int unsigned CMD_RSVD_MSB  = 6;
    localparam int unsigned CMD_RSVD_LSB  = 4;
    localparam int unsigned CMD_ADDR_MSB  = 3;
    localparam int unsigned CMD_ADDR_LSB  = 0;

    function automatic logic cmd_is_rsvd(input logic [7:0] cmd);
        return |cmd[CMD_RSVD_MSB:CMD_RSVD_LSB];
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Byte-wide register file: one synchronous write port, a display read port and a
// second combinational read port feeding the MISO byte.
module spi_reg_file #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic [3:0] tx_addr,
    output logic [7:0] tx_data
);

    logic [7:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs_q[rd_addr];
    assign tx_data = regs_q[tx_addr];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames into register-file writes and MISO byte loads.
// Frame = command byte (wr bit, reserved field, start address) then data bytes.
module spi_cmd_decoder #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_active,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] tx_data,
    output logic       tx_load
);

    import spi_pkg::*;

    state_e     state_q;
    logic [3:0] addr_q;
    logic       sel_prev_q;
    logic       wr_strobe_q;
    logic [3:0] wr_addr_q;
    logic [7:0] tx_data_q;
    logic       tx_load_q;

    logic       byte_fire;
    logic       rf_wr_en;
    logic [3:0] tx_addr;
    logic [7:0] rf_tx_data;

    // A byte arriving on the same cycle chip select drops is discarded.
    assign byte_fire = byte_valid && sel_active;
    assign rf_wr_en  = byte_fire && (state_q == StWrite);
    // Prefetch address: command's start address in CMD, next address in READ.
    assign tx_addr   = (state_q == StCmd) ? byte_data[CMD_ADDR_MSB:CMD_ADDR_LSB]
                                          : addr_q + 4'd1;

    spi_reg_file #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rf_wr_en),
        .wr_addr (addr_q),
        .wr_data (byte_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx_addr (tx_addr),
        .tx_data (rf_tx_data)
    );

    // sel_prev_q resets high so a select held across reset is not taken as a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= 4'h0;
            sel_prev_q  <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 4'h0;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
        end else begin
            sel_prev_q  <= sel_active;
            wr_strobe_q <= 1'b0;
            tx_load_q   <= 1'b0;
            if (!sel_active) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!sel_prev_q) begin
                            state_q <= StCmd;
                        end
                    end
                    StCmd: begin
                        if (byte_fire) begin
                            addr_q <= byte_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
                            if (cmd_is_rsvd(byte_data)) begin
                                state_q <= StDiscard;
                            end else if (byte_data[CMD_WR_BIT]) begin
                                state_q <= StWrite;
                            end else begin
                                state_q   <= StRead;
                                tx_data_q <= rf_tx_data;
                                tx_load_q <= 1'b1;
                            end
                        end
                    end
                    StWrite: begin
                        if (byte_fire) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= addr_q;
                            addr_q      <= addr_q + 4'd1;
                        end
                    end
                    StRead: begin
                        if (byte_fire) begin
                            addr_q    <= addr_q + 4'd1;
                            tx_data_q <= rf_tx_data;
                            tx_load_q <= 1'b1;
                        end
                    end
                    StDiscard: begin
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have a single clock and reset: clk, with asynchronous active-low reset rst_n.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sel_active  input  1  SPI frame in progress (chip select asserted), synchronous to clk.
REQ-005 byte_valid  input  1  one-cycle pulse: byte_data holds a complete received byte.
REQ-006 byte_data  input  8  received byte, MSB first on the wire.
REQ-007 rd_addr  input  4  register read-port address for display logic.
REQ-008 rd_data  output  8  register-file contents at rd_addr, combinational.
REQ-009 wr_strobe  output  1  one-cycle pulse on each register write.
REQ-010 wr_addr  output  4  address written, valid with wr_strobe.
REQ-011 tx_data  output  8  byte for the MISO shifter to send next.
REQ-012 tx_load  output  1  one-cycle pulse: tx_data updated.
REQ-013 NUM_REGS, default 16, number of 8-bit registers.

Function
REQ-014 SHALL implement FSM states IDLE, CMD, WRITE, READ, DISCARD.
REQ-015 IDLE -> CMD when sel_active is high; any state -> IDLE the cycle after sel_active is low.
REQ-016 In CMD, first byte_valid is the command: bit7 = 1 write, 0 read; bits6:4 must be 000; bits3:0 start address.
REQ-017 Command with bits6:4 nonzero -> DISCARD; all further bytes in the frame ignored, no writes, no tx_load.
REQ-018 Write command -> WRITE; each subsequent byte_valid writes byte_data to reg[addr], then addr increments.
REQ-019 Read command -> READ; tx_data = reg[start address] and tx_load pulses one cycle after the command byte_valid.
REQ-020 In READ, each subsequent byte_valid increments addr and loads reg[addr+1] into tx_data with a tx_load pulse one cycle later; byte_data is ignored.
REQ-021 Address increment SHALL wrap modulo 16 (0xF -> 0x0).
REQ-022 wr_strobe/wr_addr SHALL be registered, asserted the cycle after the byte_valid that causes the write.
REQ-023 A written value SHALL be visible on rd_data the cycle after byte_valid.
REQ-024 byte_valid with sel_active low SHALL be ignored.
REQ-025 byte_valid coincident with sel_active falling SHALL be dropped (no write, no tx_load).
REQ-026 Frame end mid-operation SHALL keep all previously written registers; the next frame restarts at CMD.
REQ-027 Only one write per byte_valid; back-to-back byte_valid pulses on consecutive cycles SHALL be handled.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, address 0, all registers 0x00, tx_data 0x00, tx_load 0, wr_strobe 0, wr_addr 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; decoding resumes only at a new sel_active high after rst_n release.

Structure
REQ-030 Shared package spi_pkg SHALL hold the FSM state type, NUM_REGS, CMD_WR_BIT (7), CMD_RSVD field (6:4) and CMD_ADDR field (3:0).
REQ-031 Register array SHALL be a sub-module spi_reg_file (one sync write port, one async read port, plus an internal async read port for tx_data).

Verification
REQ-032 Write frame: bytes 0x83,0xAA,0xBB -> reg3 = 0xAA, reg4 = 0xBB, wr_strobe twice with wr_addr 3 then 4.
REQ-033 Wrap: bytes 0x8F,0x11,0x22 -> reg15 = 0x11, reg0 = 0x22.
REQ-034 Read frame after REQ-032: bytes 0x03,0x00 -> tx_data 0xAA then 0xBB, each with one tx_load pulse.
REQ-035 Reserved command 0xF0 then 0x55 -> no wr_strobe, no tx_load, registers unchanged.
REQ-036 sel_active dropped after 0x85,0x12 and same-cycle byte 0x34 -> reg5 = 0x12, reg6 unchanged; next frame 0x86,0x77 -> reg6 = 0x77.
REQ-037 rst_n pulsed low mid write frame -> all rd_data reads 0x00, outputs at reset values, next frame decoded from CMD.
